demux_8_buffered: RTL and testbench
===================================

Name: demux_8_buffered

Overview:
- 1-to-8 demultiplexer with one-entry holding buffer per output channel. It is the write-side counterpart of the 8-way selection mux.
- One input word plus a 3-bit select is steered into destination slot `sel`. Each slot presents its word to its consumer under a valid/ready handshake.
- Used where a single producer (e.g. write-back path) feeds up to eight independently stalling consumers.

Parameters:
- width, 32, data word width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- in_valid  input  1  producer has a word on data_in.
- in_ready  output  1  block can accept the word addressed by sel this cycle.
- data_in  input  width  word to route.
- sel  input  3  destination channel index, 0..7.
- out_valid  output  8  bit i = slot i holds an undelivered word.
- out_ready  input  8  bit i = consumer i takes the word this cycle.
- data0..data7  output  width each  slot i contents.
- count  output  4  number of full slots, 0..8.

Behaviour:
- Per slot i: register full[i] and register buf[i]. out_valid[i] = full[i]; data_i = buf[i].
- Reset (reset=0, asynchronous): full = 8'b0, all buf = 0, count = 0.
  - in_ready is combinational and follows from full = 0, so it reads 1 during reset.
  - A word in flight at reset assertion is lost. No partial state survives.
- in_ready = ~full[sel] | out_ready[sel].
  - Combinational from sel, full and out_ready.
  - Defined even when in_valid = 0.
  - Must not depend on in_valid.
- Accept: in_valid & in_ready at a rising edge -> buf[sel] <= data_in, full[sel] <= 1.
- Drain: full[i] & out_ready[i] at a rising edge -> full[i] <= 0, unless slot i is loaded in the same cycle.
- Simultaneous load and drain of the same slot:
  - full stays 1.
  - The old word is delivered this cycle; buf takes the new word.
  - Zero-bubble throughput of one word per cycle into a single channel whose consumer is always ready.
- Any number of slots may drain in the same cycle. At most one slot loads per cycle.
- Latency: a word accepted at edge t appears on data_sel with out_valid set from edge t (visible in cycle t+1). There is no combinational path from data_in to any data_i.
- out_ready[i] while full[i] = 0: ignored, no state change.
- in_valid = 0: sel and data_in are ignored.
- buf[i] is not cleared on drain. data_i holds the last delivered word while out_valid[i] = 0; consumers must qualify it with out_valid.
- count is registered and equals popcount(full) after every edge:
  - +1 on load into an empty slot;
  - -1 per drain without reload;
  - unchanged on load+drain of the same slot.
- Producer-side rule: a word is held until accepted. Changing data_in or sel while in_valid = 1 and in_ready = 0 is permitted; the block simply evaluates the new sel.
- Full/empty boundaries:
  - count = 8 with no out_ready -> in_ready = 0 for every sel.
  - count = 0 -> all out_valid = 0.

Decomposition:
- Shared header of constants: channel count 8 and select width 3.
- Sub-module demux_slot, instantiated 8 times:
  - ports: clk, reset, load, drain, d, full, q;
  - holds full/buf and implements the load/drain priority above.
- Top level contains:
  - the sel decoder (load[i] = in_valid & in_ready & (sel == i));
  - the in_ready mux;
  - the count register.

Test Plan:
- Reset, then idle: reset=0 for 2 cycles mid-stream with slots 2 and 5 full -> immediately out_valid = 0, count = 0, data2 = data5 = 0, in_ready = 1.
- Single route: in_valid=1, sel=3, data_in=32'hDEADBEEF, out_ready=0.
  - Next cycle: out_valid = 8'h08, data3 = DEADBEEF, count = 1.
  - A second write to sel=3 sees in_ready = 0.
- Backpressure release: from the previous state, assert out_ready[3] with in_valid=1, sel=3, data_in=32'h12345678.
  - in_ready = 1; after the edge out_valid[3] stays 1, data3 = 12345678, count = 1.
- Fill all: write 0x100+i to sel=i for i=0..7 with out_ready=0 -> count = 8, out_valid = 8'hFF, in_ready = 0 for all sel.
  - Then out_ready = 8'hFF for one cycle -> count = 0, out_valid = 0, data_i still 0x100+i.
- Streaming: in_valid=1, sel=6, data_in incrementing 1..20, out_ready[6]=1 constantly -> in_ready = 1 every cycle, consumer 6 receives 1..20 in order with no gaps, count = 1 throughout.
- Independence: slot 1 full and stalled (out_ready[1]=0); write sel=4 -> accepted. Slot 1 value unchanged; count goes 1 -> 2.

Source files
------------

// File: rtl/demux_8_buffered_pkg.sv
// Shared constants and helpers for the buffered 1-to-8 demultiplexer.
// Channel count and select width are fixed; the count width covers 0..NUM_CH.
package demux_8_buffered_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned CNT_W  = 4;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_CH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/demux_8_buffered_slot.sv
// One-entry holding buffer for a single output channel.
// A load in the same cycle as a drain wins: the slot stays full with the new word.
module demux_slot #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             drain,
  input  logic [width-1:0] d,
  output logic             full,
  output logic [width-1:0] q
);

  // q is deliberately left untouched on drain; consumers qualify it with full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full <= 1'b0;
      q    <= '0;
    end else if (load) begin
      full <= 1'b1;
      q    <= d;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_8_buffered.sv
// Buffered 1-to-8 demultiplexer: routes one word per cycle into the slot picked
// by sel, each slot handing its word to an independent valid/ready consumer.
module demux_8_buffered
  import demux_8_buffered_pkg::*;
#(
  parameter int unsigned width = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [width-1:0]     data_in,
  input  logic [SEL_W-1:0]     sel,
  output logic [NUM_CH-1:0]    out_valid,
  input  logic [NUM_CH-1:0]    out_ready,
  output logic [width-1:0]     data0,
  output logic [width-1:0]     data1,
  output logic [width-1:0]     data2,
  output logic [width-1:0]     data3,
  output logic [width-1:0]     data4,
  output logic [width-1:0]     data5,
  output logic [width-1:0]     data6,
  output logic [width-1:0]     data7,
  output logic [CNT_W-1:0]     count
);

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] drain;
  logic [width-1:0]  slot_q [NUM_CH];
  logic              fill_empty;
  logic [CNT_W-1:0]  drained;

  // A slot can take a new word if it is empty or being emptied this cycle.
  assign in_ready = ~full[sel] | out_ready[sel];

  always_comb begin
    load = '0;
    if (in_valid && in_ready) begin
      load[sel] = 1'b1;
    end
  end

  assign drain = full & out_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    demux_slot #(
      .width(width)
    ) u_slot (
      .clk  (clk),
      .reset(reset),
      .load (load[i]),
      .drain(drain[i]),
      .d    (data_in),
      .full (full[i]),
      .q    (slot_q[i])
    );
  end

  assign out_valid = full;
  assign data0     = slot_q[0];
  assign data1     = slot_q[1];
  assign data2     = slot_q[2];
  assign data3     = slot_q[3];
  assign data4     = slot_q[4];
  assign data5     = slot_q[5];
  assign data6     = slot_q[6];
  assign data7     = slot_q[7];

  // Count tracks popcount(full) incrementally: a reload of a draining slot nets zero.
  assign fill_empty = |(load & ~full);
  assign drained    = popcount(drain & ~load);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(fill_empty) - drained;
    end
  end

endmodule

// File: tb/tb_demux_8_buffered.sv
// Randomized and directed self-checking bench for demux_8_buffered against a
// slot-level behavioural model (per-channel full flag, held word, delivery log).
module tb_demux_8_buffered;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] data_in;
  logic [2:0]   sel;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;
  logic [W-1:0] data0, data1, data2, data3, data4, data5, data6, data7;
  logic [3:0]   count;

  int n_checks = 0;
  int n_pass   = 0;

  bit           m_full [8];
  logic [W-1:0] m_buf  [8];
  logic [W-1:0] delivered [8][$];

  always #5 clk = ~clk;

  demux_8_buffered #(.width(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .data4(data4), .data5(data5), .data6(data6), .data7(data7),
    .count(count)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] dut_data(input int i);
    case (i)
      0: return data0;
      1: return data1;
      2: return data2;
      3: return data3;
      4: return data4;
      5: return data5;
      6: return data6;
      default: return data7;
    endcase
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(m_full[i]);
    return c;
  endfunction

  function automatic logic [7:0] model_valid();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_full[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_full[i] = 1'b0;
      m_buf[i]  = '0;
    end
  endtask

  task automatic check_state();
    check("out_valid", W'(out_valid), W'(model_valid()));
    check("count", W'(count), W'(model_count()));
    for (int i = 0; i < 8; i++) check($sformatf("data%0d", i), dut_data(i), m_buf[i]);
  endtask

  // Applies the current inputs across one rising edge and verifies the result.
  task automatic cycle();
    bit accept;
    #1;
    accept = in_valid && (!m_full[sel] || out_ready[sel]);
    check("in_ready", W'(in_ready), W'(!m_full[sel] || out_ready[sel]));
    for (int i = 0; i < 8; i++) begin
      if (m_full[i] && out_ready[i]) begin
        delivered[i].push_back(m_buf[i]);
        m_full[i] = 1'b0;
      end
    end
    if (accept) begin
      m_full[sel] = 1'b1;
      m_buf[sel]  = data_in;
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic drive(input bit v, input int s, input logic [W-1:0] d, input logic [7:0] rdy);
    in_valid  = v;
    sel       = 3'(s);
    data_in   = d;
    out_ready = rdy;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    drive(0, 0, '0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1 check_state();
    check("in_ready_reset", W'(in_ready), W'(1));

    // Single route and backpressure
    drive(1, 3, 32'hDEADBEEF, 8'h00);
    cycle();
    check("route_valid", W'(out_valid), W'(8'h08));
    check("route_data3", data3, 32'hDEADBEEF);
    check("route_count", W'(count), W'(1));
    drive(1, 3, 32'hCAFEF00D, 8'h00);
    #1 check("blocked_ready", W'(in_ready), W'(0));
    drive(1, 3, 32'h12345678, 8'h08);
    #1 check("release_ready", W'(in_ready), W'(1));
    cycle();
    check("release_valid3", W'(out_valid[3]), W'(1));
    check("release_data3", data3, 32'h12345678);
    check("release_count", W'(count), W'(1));
    check("release_deliv", delivered[3].pop_back(), 32'hDEADBEEF);
    drive(0, 0, '0, 8'hFF);
    cycle();

    // Fill all, then drain all at once
    for (int i = 0; i < 8; i++) begin
      drive(1, i, W'(32'h100 + i), 8'h00);
      cycle();
    end
    check("fill_count", W'(count), W'(8));
    check("fill_valid", W'(out_valid), W'(8'hFF));
    for (int i = 0; i < 8; i++) begin
      drive(1, i, 32'h0, 8'h00);
      #1 check($sformatf("full_ready%0d", i), W'(in_ready), W'(0));
    end
    drive(0, 0, '0, 8'hFF);
    cycle();
    check("drain_count", W'(count), W'(0));
    check("drain_valid", W'(out_valid), W'(0));
    for (int i = 0; i < 8; i++) check($sformatf("drain_hold%0d", i), dut_data(i), W'(32'h100 + i));

    // Streaming into channel 6
    delivered[6].delete();
    for (int k = 1; k <= 20; k++) begin
      drive(1, 6, W'(k), 8'h40);
      #1 check("stream_ready", W'(in_ready), W'(1));
      cycle();
      check("stream_count", W'(count), W'(1));
    end
    drive(0, 0, '0, 8'h40);
    cycle();
    check("stream_len", W'(delivered[6].size()), W'(20));
    for (int k = 1; k <= 20 && delivered[6].size() > 0; k++)
      check("stream_order", delivered[6].pop_front(), W'(k));

    // Independence of a stalled slot
    drive(1, 1, 32'hAAAA0001, 8'h00);
    cycle();
    check("indep_count1", W'(count), W'(1));
    drive(1, 4, 32'hBBBB0004, 8'h00);
    #1 check("indep_ready", W'(in_ready), W'(1));
    cycle();
    check("indep_count2", W'(count), W'(2));
    check("indep_data1", data1, 32'hAAAA0001);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)), W'($urandom),
            8'($urandom) & 8'($urandom));
      cycle();
    end

    // Asynchronous reset mid-stream with slots 2 and 5 full
    drive(0, 0, '0, 8'hFF);
    cycle();
    drive(1, 2, 32'h22222222, 8'h00);
    cycle();
    drive(1, 5, 32'h55555555, 8'h00);
    cycle();
    check("prereset_valid", W'(out_valid), W'(8'h24));
    drive(1, 5, 32'h99999999, 8'h00);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("rst_valid", W'(out_valid), W'(0));
    check("rst_count", W'(count), W'(0));
    check("rst_data2", data2, W'(0));
    check("rst_data5", data5, W'(0));
    check("rst_ready", W'(in_ready), W'(1));
    repeat (2) @(posedge clk);
    #1 check_state();
    @(negedge clk);
    reset = 1'b1;
    drive(1, 7, 32'h77777777, 8'h00);
    cycle();
    check("postreset_valid", W'(out_valid), W'(8'h80));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
